// File: rtl/evm_pkg.sv
// Shared types and helpers for the ballot-unit tally stage.
// Holds the FSM state encoding, default sizing and one-hot button decoding.
package evm_pkg;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int MAX_CAND     = 16;
    localparam int IDX_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // True when exactly one button is pressed.
    function automatic logic onehot_valid(input logic [MAX_CAND-1:0] v);
        return (v != '0) && ((v & (v - MAX_CAND'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CAND-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Synchronous saturating up-counter; holds at all-ones and flags it on max_hit_o.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             max_hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign max_hit_o = &cnt_q;
    assign cnt_o     = cnt_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !max_hit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Ballot-unit tally stage: arms on an authorised ballot, accepts one button press,
// commits it into per-candidate and total saturating counters, and offers readout.
module vote_tally
    import evm_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ballot_en,
    input  logic [NUM_CAND-1:0]         cand_btn,
    input  logic                        lock,
    input  logic [$clog2(NUM_CAND)-1:0] tally_sel,
    output logic                        valid_vote,
    output logic [CNT_W-1:0]            tally_out,
    output logic [CNT_W-1:0]            total_votes,
    output logic                        armed,
    output logic                        timeout,
    output logic                        multi_err,
    output logic                        sat
);

    localparam int SEL_W  = $clog2(NUM_CAND);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC);

    state_e              state_q;
    state_e              state_d;
    logic                ben_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic [SEL_W-1:0]    idx_q;
    logic [SEL_W-1:0]    idx_d;
    logic                valid_q;
    logic [CNT_W-1:0]    tally_q;
    logic [CNT_W-1:0]    tally_d;
    logic                sat_q;
    logic                sat_d;

    logic [MAX_CAND-1:0] btn_ext;
    logic                btn_one;
    logic                btn_any;
    logic                ben_rise;
    logic                wait_done;
    logic                commit;

    logic [CNT_W-1:0]    cnt [NUM_CAND];
    logic [NUM_CAND-1:0] cand_inc;
    logic [NUM_CAND-1:0] cand_max;
    logic                total_max;

    assign btn_ext   = MAX_CAND'(cand_btn);
    assign btn_one   = onehot_valid(btn_ext);
    assign btn_any   = |cand_btn;
    assign ben_rise  = ballot_en && !ben_q;
    assign wait_done = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; order inside ARMED encodes fall > timeout > press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ben_rise && !lock) state_d = ARMED;
            end
            ARMED: begin
                if (!ballot_en)     state_d = IDLE;
                else if (wait_done) state_d = IDLE;
                else if (btn_one)   state_d = COMMIT;
            end
            COMMIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!ballot_en && !btn_any) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        armed     = (state_q == ARMED);
        timeout   = (state_q == ARMED) && ballot_en && wait_done;
        multi_err = (state_q == ARMED) && btn_any && !btn_one;
        commit    = (state_q == COMMIT);
    end

    always_comb begin
        wait_d = '0;
        if (state_q == ARMED) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        idx_d = idx_q;
        if ((state_q == ARMED) && btn_one) begin
            idx_d = SEL_W'(onehot_to_idx(btn_ext));
        end
    end

    always_comb begin
        tally_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (int'(tally_sel) == i) tally_d = cnt[i];
        end
    end

    assign sat_d = sat_q | (|(cand_inc & cand_max)) | (valid_q & total_max);

    // ben_q resets high so a ballot_en already high across reset does not arm a ballot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ben_q   <= 1'b1;
            wait_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tally_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            ben_q   <= ballot_en;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            valid_q <= commit;
            tally_q <= tally_d;
            sat_q   <= sat_d;
        end
    end

    // The counters increment on the registered commit pulse, one edge after it rises.
    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        assign cand_inc[g] = valid_q && (idx_q == SEL_W'(g));

        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (reset),
            .inc_i     (cand_inc[g]),
            .cnt_o     (cnt[g]),
            .max_hit_o (cand_max[g])
        );
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_total (
        .clk       (clk),
        .rst_n     (reset),
        .inc_i     (valid_q),
        .cnt_o     (total_votes),
        .max_hit_o (total_max)
    );

    assign valid_vote = valid_q;
    assign tally_out  = tally_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: table-driven readout and saturation vectors
// plus hand-written sequences for multi-press, timeout, lock, abort and reset.
module tb_vote_tally;

    localparam int NC = 4;
    localparam int CW = 3;
    localparam int TO = 10;

    logic          clk;
    logic          reset;
    logic          ballot_en;
    logic [NC-1:0] cand_btn;
    logic          lock;
    logic [1:0]    tally_sel;
    logic          valid_vote;
    logic [CW-1:0] tally_out;
    logic [CW-1:0] total_votes;
    logic          armed;
    logic          timeout;
    logic          multi_err;
    logic          sat;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [NC-1:0] btn;
        int            exp_tally;
        int            exp_total;
        logic          exp_sat;
    } vote_vec_t;

    typedef struct {
        logic [1:0] sel;
        int         exp;
    } rd_vec_t;

    vote_vec_t sat_tbl [9];
    rd_vec_t   rd_tbl  [4];

    vote_tally #(
        .NUM_CAND    (NC),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ballot_en   (ballot_en),
        .cand_btn    (cand_btn),
        .lock        (lock),
        .tally_sel   (tally_sel),
        .valid_vote  (valid_vote),
        .tally_out   (tally_out),
        .total_votes (total_votes),
        .armed       (armed),
        .timeout     (timeout),
        .multi_err   (multi_err),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ballot_en = 1'b0;
        cand_btn  = '0;
        lock      = 1'b0;
        tally_sel = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic read_tally(input logic [1:0] sel, output int v);
        tally_sel = sel;
        tick();
        v = int'(tally_out);
    endtask

    // Full ballot: arm, press for one edge, count pulses, then release.
    task automatic do_vote(input logic [NC-1:0] btn, output int pulses);
        pulses    = 0;
        ballot_en = 1'b1;
        tick();
        cand_btn = btn;
        tick();
        cand_btn = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(valid_vote);
        end
        ballot_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int v;
        int pulses;
        int cnt;
        int tcyc;
        int cyc;

        rd_tbl[0] = '{2'd0, 0};
        rd_tbl[1] = '{2'd1, 0};
        rd_tbl[2] = '{2'd2, 1};
        rd_tbl[3] = '{2'd3, 0};

        sat_tbl[0] = '{4'b0010, 1, 1, 1'b0};
        sat_tbl[1] = '{4'b0010, 2, 2, 1'b0};
        sat_tbl[2] = '{4'b0010, 3, 3, 1'b0};
        sat_tbl[3] = '{4'b0010, 4, 4, 1'b0};
        sat_tbl[4] = '{4'b0010, 5, 5, 1'b0};
        sat_tbl[5] = '{4'b0010, 6, 6, 1'b0};
        sat_tbl[6] = '{4'b0010, 7, 7, 1'b0};
        sat_tbl[7] = '{4'b0010, 7, 7, 1'b1};
        sat_tbl[8] = '{4'b0010, 7, 7, 1'b1};

        // Reset state
        do_reset();
        check("rst_valid", int'(valid_vote), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_multi", int'(multi_err), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_total", int'(total_votes), 0);
        check("rst_tally", int'(tally_out), 0);

        // Basic vote with latency checks
        ballot_en = 1'b1;
        tick();
        check("basic_armed", int'(armed), 1);
        cand_btn = 4'b0100;
        tick();
        cand_btn = '0;
        check("basic_commit_no_pulse_yet", int'(valid_vote), 0);
        check("basic_left_armed", int'(armed), 0);
        tick();
        check("basic_pulse", int'(valid_vote), 1);
        tick();
        check("basic_pulse_single", int'(valid_vote), 0);
        check("basic_total", int'(total_votes), 1);
        ballot_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            read_tally(rd_tbl[i].sel, v);
            check($sformatf("basic_tally%0d", i), v, rd_tbl[i].exp);
        end

        // Held button and held ballot_en must not double count
        ballot_en = 1'b1;
        tick();
        cand_btn = 4'b0001;
        tick();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cnt += int'(valid_vote);
        end
        check("held_pulses", cnt, 1);
        ballot_en = 1'b0;
        cand_btn  = '0;
        tick();
        tick();
        read_tally(2'd0, v);
        check("held_cnt0_first", v, 1);
        do_vote(4'b0001, pulses);
        check("held_revote_pulses", pulses, 1);
        read_tally(2'd0, v);
        check("held_cnt0_second", v, 2);
        check("held_total", int'(total_votes), 3);

        // Multi-press then timeout
        cnt = 0;
        ballot_en = 1'b1;
        tick();
        cand_btn = 4'b0011;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) tick();
            cnt += int'(multi_err);
        end
        check("multi_err_cycles", cnt, 3);
        cand_btn = '0;
        #1;
        check("multi_err_cleared", int'(multi_err), 0);
        cyc  = 3;
        tcyc = -1;
        cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            cnt += int'(valid_vote);
            if (timeout) begin
                tcyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        check("timeout_cycle", tcyc, 10);
        check("timeout_no_vote", cnt, 0);
        tick();
        check("timeout_single", int'(timeout), 0);
        check("timeout_disarmed", int'(armed), 0);
        tick();
        check("timeout_no_rearm", int'(armed), 0);
        ballot_en = 1'b0;
        tick();
        check("timeout_total_kept", int'(total_votes), 3);

        // Saturation: nine ballots for candidate 1 on a 3-bit counter
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_vote(sat_tbl[i].btn, pulses);
            check($sformatf("sat_pulse%0d", i), pulses, 1);
            read_tally(2'd1, v);
            check($sformatf("sat_tally%0d", i), v, sat_tbl[i].exp_tally);
            check($sformatf("sat_total%0d", i), int'(total_votes), sat_tbl[i].exp_total);
            check($sformatf("sat_flag%0d", i), int'(sat), int'(sat_tbl[i].exp_sat));
        end

        // Lock blocks arming; a rise under lock is lost
        do_reset();
        check("lock_sat_cleared", int'(sat), 0);
        lock      = 1'b1;
        ballot_en = 1'b1;
        tick();
        check("lock_no_arm", int'(armed), 0);
        cand_btn = 4'b0100;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cnt += int'(valid_vote);
        end
        check("lock_press_ignored", cnt, 0);
        cand_btn = '0;
        lock     = 1'b0;
        tick();
        check("lock_drop_no_rearm", int'(armed), 0);
        ballot_en = 1'b0;
        tick();

        // Abort by dropping ballot_en
        ballot_en = 1'b1;
        tick();
        check("abort_armed", int'(armed), 1);
        ballot_en = 1'b0;
        tick();
        check("abort_idle", int'(armed), 0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cnt += int'(timeout) + int'(valid_vote);
            tick();
        end
        check("abort_no_events", cnt, 0);

        // Lock rising mid-ballot does not abort
        ballot_en = 1'b1;
        tick();
        lock = 1'b1;
        tick();
        check("lock_mid_armed", int'(armed), 1);
        cand_btn = 4'b1000;
        tick();
        cand_btn = '0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            cnt += int'(valid_vote);
        end
        check("lock_mid_pulse", cnt, 1);
        ballot_en = 1'b0;
        lock      = 1'b0;
        tick();
        tick();
        read_tally(2'd3, v);
        check("lock_mid_cnt3", v, 1);
        check("lock_mid_total", int'(total_votes), 1);

        // Reset mid-ballot discards the pending press
        ballot_en = 1'b1;
        tick();
        check("rstmid_armed", int'(armed), 1);
        cand_btn = 4'b0010;
        reset    = 1'b0;
        tick();
        check("rstmid_valid", int'(valid_vote), 0);
        check("rstmid_armed_cleared", int'(armed), 0);
        check("rstmid_total", int'(total_votes), 0);
        check("rstmid_tally", int'(tally_out), 0);
        check("rstmid_sat", int'(sat), 0);
        reset     = 1'b1;
        cand_btn  = '0;
        ballot_en = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            cnt += int'(valid_vote);
        end
        check("rstmid_no_pulse", cnt, 0);
        read_tally(2'd1, v);
        check("rstmid_cnt1", v, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
